mul_share_ctrl: RTL and testbench

- Sequencing and arbitration controller for the shared shift-add multiplier (`mul`: ld/a/b in, y out, fixed multi-cycle latency).
- Accepts multiply requests from two independent requesters over a req/done handshake.
- Arbitrates between them round-robin, latches the winner's operands and pulses the multiplier load.
- Waits a fixed number of cycles, captures the product and returns it with a one-cycle done strobe to the winner.

---
 rtl/mul_share_ctrl.sv | 116 +++++++++++
 tb/tb_mul_share_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// Round-robin front end for the shared shift-add multiplier: grants one of two
// requesters, loads the multiplier, waits a fixed latency and returns the product.
module mul_share_ctrl #(
    parameter int WIDTH      = 4,
    parameter int MUL_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   y_out,
    output logic                 busy,
    output logic                 mul_ld,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_y
);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state, state_nxt;
    logic       ptr;
    logic       sel;
    logic       win;
    logic       any_req;
    logic [3:0] cnt;
    logic       busy_nxt;
    logic       ld_nxt;
    logic       done0_nxt;
    logic       done1_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Contention goes to ptr; a lone requester wins regardless of ptr.
    always_comb begin
        any_req   = req0 | req1;
        win       = (req0 && req1) ? ptr : req1;
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        busy_nxt  = (state_nxt != IDLE);
        ld_nxt    = (state_nxt == LOAD);
        done0_nxt = (state_nxt == DONE) && !sel;
        done1_nxt = (state_nxt == DONE) && sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            mul_ld <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            busy   <= busy_nxt;
            mul_ld <= ld_nxt;
            done0  <= done0_nxt;
            done1  <= done1_nxt;
        end
    end

    // mul_y is only trusted on the last BUSY edge; earlier values are partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= 1'b0;
            sel   <= 1'b0;
            cnt   <= 4'd0;
            mul_a <= '0;
            mul_b <= '0;
            y_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel   <= win;
                        mul_a <= win ? a1 : a0;
                        mul_b <= win ? b1 : b0;
                    end
                end
                LOAD: cnt <= CNT_LOAD;
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        y_out <= mul_y;
                    end
                end
                DONE:    ptr <= ~sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: a transaction-level reference predicts grants,
// done timing and products; a negedge monitor compares every cycle.
module tb_mul_share_ctrl;

    localparam int WIDTH      = 4;
    localparam int MUL_CYCLES = 5;
    localparam int LAT        = MUL_CYCLES + 2;

    logic               clk;
    logic               rst;
    logic               req0, req1;
    logic [WIDTH-1:0]   a0, b0, a1, b1;
    logic               done0, done1;
    logic [2*WIDTH-1:0] y_out;
    logic               busy;
    logic               mul_ld;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic [2*WIDTH-1:0] mul_y;

    mul_share_ctrl #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .y_out(y_out), .busy(busy),
        .mul_ld(mul_ld), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, expv);
        end
    endfunction

    // Multiplier model: product appears only in the final cycle of the wait, 0xFF otherwise.
    logic [2*WIDTH-1:0] m_prod;
    int                 m_cnt = 0;
    initial mul_y = 8'hFF;
    always @(posedge clk) begin
        if (mul_ld) begin
            m_prod <= mul_a * mul_b;
            m_cnt  <= MUL_CYCLES - 1;
            mul_y  <= (MUL_CYCLES == 1) ? mul_a * mul_b : 8'hFF;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
            mul_y <= 8'hFF;
        end else if (m_cnt == 1) begin
            m_cnt <= 0;
            mul_y <= m_prod;
        end else begin
            mul_y <= 8'hFF;
        end
    end

    // Reference: grant rules applied at each sampled edge, expected results queued.
    typedef struct { int who; int prod; int due; } exp_t;
    exp_t sb[$];

    int cyc       = 0;
    bit armed     = 0;
    int ref_ptr   = 0;
    int idle_at   = 0;
    int ld_cycle  = -1;
    int ld_a      = 0;
    int ld_b      = 0;
    int busy_from = 0;
    int busy_to   = -1;
    int rst_cycle = -1;

    always @(posedge clk) begin
        int c, w, pa, pb;
        c = cyc;
        if (rst) begin
            sb.delete();
            ref_ptr   = 0;
            idle_at   = c + 1;
            ld_cycle  = -1;
            busy_from = 0;
            busy_to   = -1;
            rst_cycle = c + 1;
            armed     = 1;
        end else if (armed && c >= idle_at && (req0 || req1)) begin
            if (req0 && req1) w = ref_ptr;
            else              w = req1 ? 1 : 0;
            pa = (w == 1) ? int'(a1) : int'(a0);
            pb = (w == 1) ? int'(b1) : int'(b0);
            sb.push_back('{w, pa * pb, c + LAT});
            ld_cycle  = c + 1;
            ld_a      = pa;
            ld_b      = pb;
            busy_from = c + 1;
            busy_to   = c + LAT;
            idle_at   = c + LAT + 1;
            ref_ptr   = 1 - w;
        end
        cyc = c + 1;
    end

    int y_exp = 0;
    always @(negedge clk) begin
        int c;
        exp_t e;
        if (armed) begin
            c = cyc;
            if (c == rst_cycle) begin
                y_exp = 0;
                chk("rst_mul_a", mul_a, 0);
                chk("rst_mul_b", mul_b, 0);
            end
            chk("done_exclusive", done0 && done1, 0);
            chk("done_vs_ld", (done0 || done1) && mul_ld, 0);
            if (sb.size() > 0 && sb[0].due == c) begin
                e = sb.pop_front();
                chk("done0_strobe", done0, e.who == 0);
                chk("done1_strobe", done1, e.who == 1);
                chk("y_at_done", y_out, e.prod);
                y_exp = e.prod;
            end else begin
                chk("done0_quiet", done0, 0);
                chk("done1_quiet", done1, 0);
                chk("y_hold", y_out, y_exp);
            end
            chk("mul_ld", mul_ld, c == ld_cycle);
            chk("busy", busy, (c >= busy_from) && (c <= busy_to));
            if (ld_cycle >= 0 && c >= ld_cycle && c <= busy_to) begin
                chk("mul_a_held", mul_a, ld_a);
                chk("mul_b_held", mul_b, ld_b);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int k, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((k == 0) ? done0 : done1) !== 1'b1 && n < 40);
        chk(nm, (k == 0) ? done0 : done1, 1);
    endtask

    task automatic wait_any(output int who);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done0 === 1'b1 || done1 === 1'b1) && n < 40);
        chk("any_done_seen", done0 | done1, 1);
        who = (done1 === 1'b1) ? 1 : 0;
    endtask

    task automatic drive(input logic dn, inout logic rq, inout logic [WIDTH-1:0] a,
                         inout logic [WIDTH-1:0] b);
        if (rq) begin
            if (dn) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = WIDTH'($urandom_range(0, 15));
                    b = WIDTH'($urandom_range(0, 15));
                end else begin
                    rq = 1'b0;
                end
            end else if ($urandom_range(0, 49) == 0) begin
                rq = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                a = WIDTH'($urandom_range(0, 15));
            end
        end else if ($urandom_range(0, 3) == 0) begin
            rq = 1'b1;
            a  = WIDTH'($urandom_range(0, 15));
            b  = WIDTH'($urandom_range(0, 15));
        end
    endtask

    initial begin
        int n, who;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);

        // single request
        do_reset();
        req0 = 1'b1; a0 = 4'b1101; b0 = 4'b1011;
        wait_done(0, "s1_done0", n);
        chk("s1_latency", n, LAT);
        chk("s1_y", y_out, 143);
        chk("s1_done1", done1, 0);
        req0 = 1'b0;

        // simultaneous requests
        do_reset();
        req0 = 1'b1; a0 = 4'd9;  b0 = 4'd6;
        req1 = 1'b1; a1 = 4'd15; b1 = 4'd15;
        wait_done(0, "s2_first", n);
        chk("s2_y0", y_out, 54);
        req0 = 1'b0;
        wait_done(1, "s2_second", n);
        chk("s2_gap", n, LAT + 1);
        chk("s2_y1", y_out, 225);
        req1 = 1'b0;

        // round robin under contention, then a lone requester back-to-back
        do_reset();
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd4;
        req1 = 1'b1; a1 = 4'd5; b1 = 4'd6;
        for (int i = 0; i < 4; i++) begin
            wait_any(who);
            chk("s3_order", who, i % 2);
            if (who == 0) begin a0 = WIDTH'(i + 1); b0 = 4'd7; end
            else          begin a1 = WIDTH'(i + 2); b1 = 4'd9; end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        req1 = 1'b1; a1 = 4'd4; b1 = 4'd4;
        wait_done(1, "s3_lone_a", n);
        chk("s3_lone_y_a", y_out, 16);
        a1 = 4'd5; b1 = 4'd5;
        wait_done(1, "s3_lone_b", n);
        chk("s3_back_to_back", n, LAT + 1);
        chk("s3_lone_y_b", y_out, 25);
        req1 = 1'b0;
        repeat (2) @(negedge clk);

        // reset in the middle of BUSY
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd3;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_y", y_out, 0);
        chk("s5_done0", done0, 0);
        wait_done(0, "s5_reissue", n);
        chk("s5_latency", n, LAT);
        chk("s5_y_final", y_out, 21);
        req0 = 1'b0;

        // operands scribbled while busy
        @(negedge clk);
        req1 = 1'b1; a1 = 4'd2; b1 = 4'd3;
        repeat (3) @(negedge clk);
        a1 = 4'd9; b1 = 4'd9; a0 = 4'd12; b0 = 4'd12;
        wait_done(1, "s6_done1", n);
        chk("s6_y", y_out, 6);
        req1 = 1'b0;

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            drive(done0, req0, a0, b0);
            drive(done1, req1, a1, b1);
        end
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (20) @(negedge clk);
        chk("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
